detector_jogada: RTL
====================

# detector_jogada

Input-conditioning stage upstream of the experiment's control unit. Synchronizes and debounces the four raw `chaves` switches. Accepts only a stable one-hot pattern as a play: latches it into `jogada` and emits a one-cycle `jogada_feita` pulse. Stable multi-bit patterns are rejected with `jogada_invalida`. Each play must be released before the next one is accepted, so one press produces exactly one pulse.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles an input pattern must stay unchanged to be accepted. Must be ≥ 2.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low. Clears all registers at the next rising edge while low.
- `habilita` in 1: enables detection; 0 parks the FSM in INICIAL.
- `limpa` in 1: synchronous clear of `jogada` to 0000.
- `chaves` in 4: raw, asynchronous switch/button inputs.
- `jogada` out 4: last accepted one-hot play; registered; held until the next accepted play, `limpa`, or reset.
- `jogada_feita` out 1: one-cycle pulse, high while in REGISTRA.
- `jogada_invalida` out 1: one-cycle pulse, high while in INVALIDA.
- `ocupado` out 1: high in every state except INICIAL and ESPERA.
- `db_estado` out 4: current state code, for the 7-segment debug display.

## Operation
- Synchronizer:
  - two flops on `chaves`; second stage is `chaves_s`.
  - FSM and counters use only `chaves_s`.
- Datapath:
  - `amostra` (4 b) holds the candidate pattern.
  - `cont` is a stability counter of width clog2(DEBOUNCE_CYCLES)+1.
- States (db_estado code):
  - INICIAL 0000. `habilita`=1 → ESPERA_SOLTAR. It goes to ESPERA_SOLTAR, not ESPERA, so a switch already held at enable is never taken as a play.
  - ESPERA 0001. `chaves_s`≠0 → FILTRA, with `amostra`←`chaves_s`, `cont`←0.
  - FILTRA 0010:
    - `chaves_s`=0 → ESPERA.
    - `chaves_s`≠`amostra` → `amostra`←`chaves_s`, `cont`←0, stay.
    - equal and `cont`<D−1 → `cont`++.
    - equal and `cont`=D−1 and `amostra` one-hot → REGISTRA, `jogada`←`amostra`.
    - equal and `cont`=D−1 and not one-hot → INVALIDA.
  - REGISTRA 0011 → ESPERA_SOLTAR unconditionally, `cont`←0.
  - INVALIDA 1110 → ESPERA_SOLTAR unconditionally, `cont`←0.
  - ESPERA_SOLTAR 0100:
    - `chaves_s`≠0 → `cont`←0.
    - `chaves_s`=0 and `cont`<D−1 → `cont`++.
    - `chaves_s`=0 and `cont`=D−1 → ESPERA.
- `habilita`=0:
  - In ESPERA, FILTRA or ESPERA_SOLTAR → INICIAL next edge, `cont`←0.
  - REGISTRA and INVALIDA always complete their single cycle; the next edge then goes to INICIAL instead of ESPERA_SOLTAR.
  - `jogada` is retained.
- `limpa`=1 clears `jogada` at the edge, except when that edge loads `jogada` on entry to REGISTRA: the load wins.
- One-hot check: exactly one of the 4 bits set. Patterns 0000 never reach the check.

## Timing
- Reset (`reset`=0 at an edge) sets:
  - state INICIAL, db_estado 0000;
  - `jogada`=0000, `jogada_feita`=0, `jogada_invalida`=0, `ocupado`=0;
  - `amostra`=0000, `cont`=0, synchronizer flops 0.
- Reset mid-operation (any state) aborts at once: no pulse is emitted, and `jogada` is cleared.
- Latency, with edge 0 the first edge that samples the new `chaves` and the pattern held stable from ESPERA:
  - FILTRA entered at edge 2;
  - REGISTRA or INVALIDA entered at edge D+2;
  - the pulse is high for the cycle after edge D+2. With D=4, that is edge 6.
- `jogada` updates at the same edge `jogada_feita` rises, so it is valid while the pulse is high.
- Release: ESPERA_SOLTAR returns to ESPERA after D consecutive edges with `chaves_s`=0.
- Any bounce restarts the count: one cycle of a different pattern in FILTRA, or one nonzero cycle in ESPERA_SOLTAR.
- All outputs are registered or decoded from state only (Moore); no input reaches an output combinationally.

## Test plan
All scenarios use D=4 and a 20 ns clock.
1. Reset: `reset`=0 for 1 cycle with `chaves`=0101 → all outputs 0, db_estado 0000; after release, state stays INICIAL while `habilita`=0.
2. Clean play:
   - Stimulus: `habilita`=1, 0000 for 6 cycles (state reaches ESPERA), then `chaves`=0100 for 10 cycles, then 0000.
   - Response: exactly one `jogada_feita` pulse, in the cycle after edge 6; `jogada`=0100 from then on; db_estado 0100 while held, 0001 after 6 cycles of 0000.
3. Bounce: from ESPERA apply 0100 for 2 cycles, 0000 for 1, 0010 for 1, then 0100 held → one pulse only, 6 edges after the final 0100 is first sampled; `jogada`=0100.
4. Invalid: from ESPERA with `jogada`=0100, apply `chaves`=0110 held → one `jogada_invalida` pulse; `jogada_feita` never rises; `jogada` stays 0100.
5. Held at enable: `chaves`=1000 held, then `habilita` 0→1 → no pulse while held; release 0000 for 6 cycles, press 1000 → one pulse, `jogada`=1000.
6. Mid-operation:
   - `reset`=0 during FILTRA → INICIAL, no pulse, `jogada`=0000.
   - `limpa`=1 in ESPERA_SOLTAR → `jogada`=0000 next cycle.

Source files
------------

// File: rtl/detector_jogada.sv
// Switch input conditioning: two-flop synchronizer, debounce FSM and play register.
// A stable one-hot pattern becomes a play; multi-bit patterns are flagged as invalid.
module detector_jogada #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       limpa,
    input  logic [3:0] chaves,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       jogada_invalida,
    output logic       ocupado,
    output logic [3:0] db_estado
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'b0000,
        ESPERA        = 4'b0001,
        FILTRA        = 4'b0010,
        REGISTRA      = 4'b0011,
        ESPERA_SOLTAR = 4'b0100,
        INVALIDA      = 4'b1110
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [3:0]    sync_q;
    logic [3:0]    chaves_s_q;
    logic [3:0]    amostra_q, amostra_d;
    logic [CW-1:0] cont_q, cont_d;
    logic [3:0]    jogada_q, jogada_d;
    logic          amostra_um_quente;

    assign amostra_um_quente = ($countones(amostra_q) == 1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q   <= INICIAL;
            sync_q     <= '0;
            chaves_s_q <= '0;
            amostra_q  <= '0;
            cont_q     <= '0;
            jogada_q   <= '0;
        end else begin
            estado_q   <= estado_d;
            sync_q     <= chaves;
            chaves_s_q <= sync_q;
            amostra_q  <= amostra_d;
            cont_q     <= cont_d;
            jogada_q   <= jogada_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        amostra_d = amostra_q;
        cont_d    = cont_q;
        jogada_d  = limpa ? 4'b0000 : jogada_q;

        case (estado_q)
            INICIAL: begin
                // Enabling goes through the release wait so a switch already held is ignored
                if (habilita) begin
                    estado_d = ESPERA_SOLTAR;
                    cont_d   = '0;
                end
            end
            ESPERA: begin
                if (!habilita) begin
                    estado_d = INICIAL;
                    cont_d   = '0;
                end else if (chaves_s_q != 4'b0000) begin
                    estado_d  = FILTRA;
                    amostra_d = chaves_s_q;
                    cont_d    = '0;
                end
            end
            FILTRA: begin
                if (!habilita) begin
                    estado_d = INICIAL;
                    cont_d   = '0;
                end else if (chaves_s_q == 4'b0000) begin
                    estado_d = ESPERA;
                end else if (chaves_s_q != amostra_q) begin
                    amostra_d = chaves_s_q;
                    cont_d    = '0;
                end else if (cont_q != CONT_MAX) begin
                    cont_d = cont_q + CW'(1);
                end else if (amostra_um_quente) begin
                    estado_d = REGISTRA;
                    jogada_d = amostra_q;
                end else begin
                    estado_d = INVALIDA;
                end
            end
            REGISTRA, INVALIDA: begin
                estado_d = habilita ? ESPERA_SOLTAR : INICIAL;
                cont_d   = '0;
            end
            ESPERA_SOLTAR: begin
                if (!habilita) begin
                    estado_d = INICIAL;
                    cont_d   = '0;
                end else if (chaves_s_q != 4'b0000) begin
                    cont_d = '0;
                end else if (cont_q != CONT_MAX) begin
                    cont_d = cont_q + CW'(1);
                end else begin
                    estado_d = ESPERA;
                end
            end
            default: begin
                estado_d = INICIAL;
                cont_d   = '0;
            end
        endcase
    end

    assign jogada          = jogada_q;
    assign jogada_feita    = (estado_q == REGISTRA);
    assign jogada_invalida = (estado_q == INVALIDA);
    assign ocupado         = (estado_q != INICIAL) && (estado_q != ESPERA);
    assign db_estado       = estado_q;

endmodule
